// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle main FSM and the shared datapath.
// Latency: none (wires only).
// Backpressure: mem_ready from memory stalls the controller in memory-access states.
interface multi_cycle_control_if;
    logic [5:0]  op;
    logic        mem_ready;
    logic        pc_write;
    logic        branch;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_src;
    logic        instr_done;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    modport master (
        input  op, mem_ready,
        output pc_write, branch, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, instr_done, illegal_op, state, instr_count
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, branch, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, instr_done, illegal_op, state, instr_count
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS-32 datapath; one state per datapath step.
// Latency: lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles with memory always ready.
// Backpressure: mem_ready low in FETCH/MEMRD/MEMWR holds state and outputs for that cycle.
module multi_cycle_control (
    input  logic                        clk,
    input  logic                        rst,
    multi_cycle_control_if.master       bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q, state_d;
    logic [31:0] count_q;

    logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       instr_done, illegal_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Precompute branch target while the opcode is decoded.
                alu_src_b = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset abandons any instruction in flight: no strobes, FETCH mux selects.
        if (rst) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.branch      = branch;
    assign bus.iord        = iord;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.ir_write    = ir_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.reg_dst     = reg_dst;
    assign bus.reg_write   = reg_write;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_op      = alu_op;
    assign bus.pc_src      = pc_src;
    assign bus.instr_done  = instr_done;
    assign bus.illegal_op  = illegal_op;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed per-cycle vectors push expected
// state/control/count records; a negedge monitor pops and compares them.
module tb_multi_cycle_control;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    multi_cycle_control_if bus();

    multi_cycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected control word from the per-state output table of the datapath.
    function automatic ctl_t expect_ctl(logic r, logic [3:0] st, logic [5:0] o, logic mr);
        ctl_t e;
        e       = '0;
        e.state = st;
        if (r) begin
            e.alu_src_b = 2'b01;
            return e;
        end
        case (st)
            4'd0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            4'd1:  begin
                       e.alu_src_b  = 2'b11;
                       e.illegal_op = !(o == OP_R || o == OP_LW || o == OP_SW ||
                                        o == OP_BEQ || o == OP_ADDI || o == OP_J);
                   end
            4'd2,
            4'd9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.iord = 1'b1; e.mem_read = 1'b1; end
            4'd4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = mr; end
            4'd6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            4'd7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            4'd8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
                         e.branch = 1'b1; e.instr_done = 1'b1; end
            4'd10: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            4'd11: begin e.pc_src = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle of stimulus with its hand-derived expected state and count.
    task automatic step(input logic r, input logic [5:0] o, input logic mr,
                        input logic [3:0] st, input logic [31:0] cnt);
        exp_t e;
        rst           = r;
        bus.op        = o;
        bus.mem_ready = mr;
        e.ctl         = expect_ctl(r, st, o, mr);
        e.cnt         = cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ctl_t act;
        exp_t e;
        cyc = cyc + 1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act.state      = bus.state;
            act.pc_write   = bus.pc_write;
            act.branch     = bus.branch;
            act.iord       = bus.iord;
            act.mem_read   = bus.mem_read;
            act.mem_write  = bus.mem_write;
            act.ir_write   = bus.ir_write;
            act.mem_to_reg = bus.mem_to_reg;
            act.reg_dst    = bus.reg_dst;
            act.reg_write  = bus.reg_write;
            act.alu_src_a  = bus.alu_src_a;
            act.alu_src_b  = bus.alu_src_b;
            act.alu_op     = bus.alu_op;
            act.pc_src     = bus.pc_src;
            act.instr_done = bus.instr_done;
            act.illegal_op = bus.illegal_op;
            n_checks = n_checks + 1;
            if (act !== e.ctl) begin
                n_fail = n_fail + 1;
                $display("FAIL ctl cycle %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         cyc, act.state, act, e.ctl.state, e.ctl);
            end
            n_checks = n_checks + 1;
            if (bus.instr_count !== e.cnt) begin
                n_fail = n_fail + 1;
                $display("FAIL instr_count cycle %0d: got %0d want %0d", cyc, bus.instr_count, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.op        = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1, OP_R, 1, 4'd0, 0);

        // R-type: 0,1,6,7
        step(0, OP_R, 1, 4'd0, 0);
        step(0, OP_R, 1, 4'd1, 0);
        step(0, OP_R, 1, 4'd6, 0);
        step(0, OP_R, 1, 4'd7, 0);

        // lw then sw, memory always ready
        step(0, OP_LW, 1, 4'd0, 1);
        step(0, OP_LW, 1, 4'd1, 1);
        step(0, OP_LW, 1, 4'd2, 1);
        step(0, OP_LW, 1, 4'd3, 1);
        step(0, OP_LW, 1, 4'd4, 1);
        step(0, OP_SW, 1, 4'd0, 2);
        step(0, OP_SW, 1, 4'd1, 2);
        step(0, OP_SW, 1, 4'd2, 2);
        step(0, OP_SW, 1, 4'd5, 2);

        // lw with 3 stall cycles in FETCH and 2 in MEMRD
        step(0, OP_LW, 0, 4'd0, 3);
        step(0, OP_LW, 0, 4'd0, 3);
        step(0, OP_LW, 0, 4'd0, 3);
        step(0, OP_LW, 1, 4'd0, 3);
        step(0, OP_LW, 0, 4'd1, 3);
        step(0, OP_LW, 0, 4'd2, 3);
        step(0, OP_LW, 0, 4'd3, 3);
        step(0, OP_LW, 0, 4'd3, 3);
        step(0, OP_LW, 1, 4'd3, 3);
        step(0, OP_LW, 0, 4'd4, 3);

        // beq then j
        step(0, OP_BEQ, 1, 4'd0, 4);
        step(0, OP_BEQ, 1, 4'd1, 4);
        step(0, OP_BEQ, 1, 4'd8, 4);
        step(0, OP_J,   1, 4'd0, 5);
        step(0, OP_J,   1, 4'd1, 5);
        step(0, OP_J,   1, 4'd11, 5);

        // illegal opcode: dropped, not counted
        step(0, OP_BAD, 1, 4'd0, 6);
        step(0, OP_BAD, 1, 4'd1, 6);

        // addi
        step(0, OP_ADDI, 1, 4'd0, 6);
        step(0, OP_ADDI, 1, 4'd1, 6);
        step(0, OP_ADDI, 1, 4'd9, 6);
        step(0, OP_ADDI, 1, 4'd10, 6);

        // sw stalled in MEMWR, then reset abandons it
        step(0, OP_SW, 1, 4'd0, 7);
        step(0, OP_SW, 1, 4'd1, 7);
        step(0, OP_SW, 0, 4'd2, 7);
        step(0, OP_SW, 0, 4'd5, 7);
        step(0, OP_SW, 0, 4'd5, 7);
        step(1, OP_SW, 0, 4'd5, 7);
        step(1, OP_SW, 0, 4'd0, 0);

        // Recovery after reset
        step(0, OP_R, 1, 4'd0, 0);
        step(0, OP_R, 1, 4'd1, 0);
        step(0, OP_R, 1, 4'd6, 0);
        step(0, OP_R, 1, 4'd7, 0);
        step(0, OP_R, 0, 4'd0, 1);

        @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
